// File: rtl/vga_pkg.sv
// Shared timing, colour and counter definitions for the register-file VGA viewer.
package vga_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [4:0]       rgb_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // {red[1:0], green[1:0], blue}
  localparam rgb_t COL_BORDER = 5'b00_00_1;
  localparam rgb_t COL_ONE    = 5'b00_11_0;
  localparam rgb_t COL_ZERO   = 5'b01_00_0;
  localparam rgb_t COL_BLACK  = 5'b00_00_0;

  function automatic cnt_t cnt_inc(input cnt_t value, input cnt_t last);
    return (value == last) ? '0 : value + 1'b1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with sync, active-region and frame-origin decode.
module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en_i,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic [9:0] vnext_o,
  output logic       line_end_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       active_o,
  output logic       frame_start_o
);
  import vga_pkg::cnt_t;
  import vga_pkg::cnt_inc;

  localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  cnt_t hcount_q, hcount_d;
  cnt_t vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_i) begin
      hcount_d = cnt_inc(hcount_q, H_LAST);
      if (hcount_q == H_LAST) vcount_d = cnt_inc(vcount_q, V_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign vnext_o       = cnt_inc(vcount_q, V_LAST);
  assign line_end_o    = (hcount_q == H_LAST);
  assign hsync_n_o     = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
  assign vsync_n_o     = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
  assign active_o      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign frame_start_o = (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: rtl/vga_regview.sv
// 16x16 bit-grid view of the register file on VGA: row fetch, colouring, output register.
module vga_regview #(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter int ORIGIN_X  = 192,
  parameter int ORIGIN_Y  = 112,
  parameter int CELL_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [3:0]  ra,
  input  logic [15:0] rd,
  output logic [6:0]  vga,
  output logic        frame_start
);
  import vga_pkg::cnt_t;
  import vga_pkg::rgb_t;
  import vga_pkg::COL_BORDER;
  import vga_pkg::COL_ONE;
  import vga_pkg::COL_ZERO;
  import vga_pkg::COL_BLACK;

  localparam cnt_t GRID_W    = cnt_t'(16 << CELL_LOG2);
  localparam cnt_t OX        = cnt_t'(ORIGIN_X);
  localparam cnt_t OY        = cnt_t'(ORIGIN_Y);
  localparam cnt_t CELL_MASK = cnt_t'((1 << CELL_LOG2) - 1);

  cnt_t hcount, vcount, vnext;
  logic line_end, hsync_n, vsync_n, active, at_origin;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .pix_en_i     (pix_en),
    .hcount_o     (hcount),
    .vcount_o     (vcount),
    .vnext_o      (vnext),
    .line_end_o   (line_end),
    .hsync_n_o    (hsync_n),
    .vsync_n_o    (vsync_n),
    .active_o     (active),
    .frame_start_o(at_origin)
  );

  logic [3:0]  ra_q, ra_d;
  logic [15:0] row_buf_q, row_buf_d;
  logic [6:0]  vga_q, vga_d;
  logic        fs_q, fs_d;

  cnt_t       dx, dy, ny;
  logic [3:0] col;
  logic       in_grid, on_border;
  rgb_t       pix_rgb;

  // Offsets wrap modulo 2^10, so one unsigned compare covers both grid edges.
  always_comb begin
    dx        = hcount - OX;
    dy        = vcount - OY;
    ny        = vnext - OY;
    col       = 4'(dx >> CELL_LOG2);
    in_grid   = active && (dx < GRID_W) && (dy < GRID_W);
    on_border = ((dx & CELL_MASK) == '0) || ((dy & CELL_MASK) == '0);
    pix_rgb   = COL_BLACK;
    if (in_grid) begin
      if (on_border)              pix_rgb = COL_BORDER;
      else if (row_buf_q[~col])   pix_rgb = COL_ONE;
      else                        pix_rgb = COL_ZERO;
    end
  end

  // The row address is set one tick before the line so rd is settled at hcount 0.
  always_comb begin
    ra_d      = ra_q;
    row_buf_d = row_buf_q;
    vga_d     = vga_q;
    fs_d      = 1'b0;
    if (pix_en) begin
      if (line_end && (ny < GRID_W)) ra_d = 4'(ny >> CELL_LOG2);
      if (hcount == '0)              row_buf_d = rd;
      vga_d = {hsync_n, vsync_n, pix_rgb};
      fs_d  = at_origin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q      <= '0;
      row_buf_q <= '0;
      vga_q     <= {1'b1, 1'b1, COL_BLACK};
      fs_q      <= 1'b0;
    end else begin
      ra_q      <= ra_d;
      row_buf_q <= row_buf_d;
      vga_q     <= vga_d;
      fs_q      <= fs_d;
    end
  end

  assign ra          = ra_q;
  assign vga         = vga_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_regview.sv
// Bench for vga_regview with a shrunken raster so whole frames fit a short run.
module tb_vga_regview;
  localparam int HA = 80, HFP = 4, HSW = 8, HBP = 8;
  localparam int VA = 72, VFP = 2, VSW = 3, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int OX = 8, OY = 4, CL = 2;
  localparam int CS = 1 << CL;
  localparam int GRID = 16 * CS;
  localparam int PY = OY + 3 * CS + CS / 2;

  logic        clk, rst, pix_en, frame_start;
  logic [3:0]  ra;
  logic [15:0] rd;
  logic [6:0]  vga;
  logic [15:0] regs [16];

  int total, bad;
  int mh, mv, exp_ra, tick_idx, last_fs, fs_pulses;
  int hs_cnt, hs_first, vs_cnt;

  assign rd = regs[ra];

  vga_regview #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .CELL_LOG2(CL)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .ra(ra), .rd(rd),
    .vga(vga), .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_vga(input int h, input int v);
    logic hs, vs;
    logic [4:0] c;
    logic [15:0] r;
    int x, y;
    hs = !(h >= HA + HFP && h < HA + HFP + HSW);
    vs = !(v >= VA + VFP && v < VA + VFP + VSW);
    c = 5'b00000;
    x = h - OX;
    y = v - OY;
    if (h < HA && v < VA && x >= 0 && x < GRID && y >= 0 && y < GRID) begin
      if (x % CS == 0 || y % CS == 0) c = 5'b00001;
      else begin
        r = regs[y / CS];
        c = r[15 - x / CS] ? 5'b00110 : 5'b01000;
      end
    end
    return {hs, vs, c};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; exp_ra = 0; tick_idx = 0; last_fs = -1;
    hs_cnt = 0; hs_first = -1; vs_cnt = 0;
  endtask

  task automatic check_reset_state();
    check("rst_vga", 16'(vga), 16'h0060);
    check("rst_fs", 16'(frame_start), 16'h0000);
    check("rst_ra", 16'(ra), 16'h0000);
  endtask

  task automatic directed_checks();
    logic [15:0] a5;
    int k, x;
    a5 = 16'hA5A5;
    x = mh - OX;
    if (mv == PY && x >= 0 && x < GRID && x % CS == CS / 2) begin
      k = x / CS;
      check("a5a5_bit", 16'(vga[4:0]), a5[15 - k] ? 16'h0006 : 16'h0008);
    end
    if (mv >= OY && mv < OY + GRID) begin
      if (mh == OX) check("border_left", 16'(vga[4:0]), 16'h0001);
      if (mh == OX - 1 || mh == OX + GRID) check("outside_grid", 16'(vga[4:0]), 16'h0000);
    end
    if (mv == OY && x >= 0 && x < GRID) check("border_top", 16'(vga[4:0]), 16'h0001);
    if (mh >= HA || mv >= VA) check("blank", 16'(vga[4:0]), 16'h0000);
  endtask

  task automatic run_ticks(input int n);
    logic [6:0] held;
    int g, nl;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); pix_en = 1'b1;
      @(negedge clk); pix_en = 1'b0;
      check("vga", 16'(vga), 16'(exp_vga(mh, mv)));
      check("frame_start", 16'(frame_start), 16'(mh == 0 && mv == 0));
      if (mh == HT - 1) begin
        nl = (mv + 1) % VT;
        if (nl >= OY && nl < OY + GRID) exp_ra = (nl - OY) / CS;
      end
      check("ra", 16'(ra), 16'(exp_ra));
      directed_checks();
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) check("fs_interval", 16'(tick_idx - last_fs), 16'(HT * VT));
        last_fs = tick_idx;
        fs_pulses++;
      end
      if (mh == 0 && mv == 0) vs_cnt = 0;
      if (vga[5] === 1'b0) vs_cnt++;
      if (vga[6] === 1'b0) begin
        if (hs_cnt == 0) hs_first = mh;
        hs_cnt++;
      end
      if (mh == HT - 1) begin
        check("hs_width", 16'(hs_cnt), 16'(HSW));
        check("hs_start", 16'(hs_first), 16'(HA + HFP));
        hs_cnt = 0; hs_first = -1;
        if (mv == VT - 1) check("vs_ticks", 16'(vs_cnt), 16'(VSW * HT));
      end
      held = vga;
      tick_idx++;
      mh++;
      if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
      g = $urandom_range(0, 1);
      repeat (g) begin
        @(negedge clk);
        check("hold_vga", 16'(vga), 16'(held));
        check("hold_fs", 16'(frame_start), 16'h0000);
      end
    end
  endtask

  initial begin
    logic [6:0] hv;
    logic [3:0] hra;
    total = 0; bad = 0; fs_pulses = 0;
    rst = 1'b1; pix_en = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    regs[3] = 16'hA5A5;

    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    model_reset();

    // One full frame plus the origin of the next.
    run_ticks(HT * VT + 1);
    check("fs_pulses_frame1", 16'(fs_pulses), 16'd2);

    // Freeze: nothing may move while pix_en is low.
    hv = vga; hra = ra;
    repeat (100) begin
      @(negedge clk);
      check("freeze_vga", 16'(vga), 16'(hv));
      check("freeze_ra", 16'(ra), 16'(hra));
      check("freeze_fs", 16'(frame_start), 16'h0000);
    end

    // Walk to a mid-frame point, then pulse reset for one clock.
    while (!(mh == 30 && mv == 20)) run_ticks(1);
    @(negedge clk);
    rst = 1'b1;
    pix_en = 1'($urandom_range(0, 1));
    @(negedge clk);
    rst = 1'b0; pix_en = 1'b0;
    check_reset_state();
    model_reset();
    fs_pulses = 0;

    run_ticks(HT * VT + 1);
    check("fs_pulses_after_rst", 16'(fs_pulses), 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
